// File: rtl/rr_priority_pick.sv
// rr_priority_pick: wrap-around first-set search of req starting at ptr
module rr_priority_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] pick,
   output logic [W-1:0] idx
);
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] rot;
   logic [N-1:0]   r;
   logic [N-1:0]   lsb;
   // rotate req so ptr sits at bit 0, isolate lowest set bit, rotate back, encode
   always_comb begin
      dbl  = {req, req} >> ptr;
      r    = dbl[N-1:0];
      lsb  = r & (~r + 1'b1);
      rot  = {lsb, lsb} << ptr;
      pick = rot[2*N-1:N];
      idx  = '0;
      for (int i = 0; i < N; i++) idx |= pick[i] ? W'(i) : '0;
   end
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: registered one-hot round-robin arbiter held until done
module onehot_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic             grant_valid,
   output logic [W_IDX-1:0] grant_idx
);
   localparam logic S_IDLE = 1'b0;
   localparam logic S_BUSY = 1'b1;
   typedef enum logic {IDLE = S_IDLE, BUSY = S_BUSY} state_t;
   state_t           state, state_n;
   logic [W_IDX-1:0] ptr, ptr_n, pick_idx, idx_n;
   logic [N_REQ-1:0] pick, grant_n;
   rr_priority_pick #(.N(N_REQ), .W(W_IDX)) u_pick (
      .req  (req),
      .ptr  (ptr),
      .pick (pick),
      .idx  (pick_idx)
   );
   // state, grant and pointer registers; every output comes straight from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         ptr         <= '0;
      end else begin
         state       <= state_n;
         grant       <= grant_n;
         grant_idx   <= idx_n;
         grant_valid <= state_n == BUSY;
         ptr         <= ptr_n;
      end
   end
   // arbitrate when idle or when the current grant finishes; otherwise hold
   always_comb begin
      state_n = state;
      grant_n = grant;
      idx_n   = grant_idx;
      ptr_n   = ptr;
      if (state == IDLE || done) begin
         state_n = |req ? BUSY : IDLE;
         grant_n = |req ? pick : '0;
         idx_n   = |req ? pick_idx : '0;
         ptr_n   = !(|req) ? ptr : (pick_idx == W_IDX'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: random and directed checks against a behavioural arbiter model
module tb_onehot_rr_arbiter;
   localparam int N = 4;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic         done = 1'b0;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [1:0]   grant_idx;
   int           total = 0;
   int           passed = 0;
   logic         m_known = 1'b0;
   logic         m_busy = 1'b0;
   int           m_ptr = 0;
   int           m_win = 0;
   logic         m_issue = 1'b0;
   logic [N-1:0] m_req = '0;
   logic         m_rst = 1'b0;
   int           wait_cnt [N];

   onehot_rr_arbiter #(.N_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always #5 clk = ~clk;

   // reference: scan priorities ptr, ptr+1, ... modulo N for the first requester
   always @(posedge clk) begin
      automatic int w = -1;
      m_known <= 1'b1;
      m_req   <= req;
      m_rst   <= rst;
      m_issue <= 1'b0;
      if (rst) begin
         m_busy <= 1'b0;
         m_ptr  <= 0;
      end else if (!m_busy || done) begin
         for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         m_busy <= w >= 0;
         if (w >= 0) begin
            m_win   <= w;
            m_ptr   <= (w + 1) % N;
            m_issue <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // compare process: DUT against model every cycle, plus fairness on DUT grants
   always @(negedge clk) begin
      if (m_known) begin
         check("grant", int'(grant), m_busy ? (1 << m_win) : 0);
         check("grant_idx", int'(grant_idx), m_busy ? m_win : 0);
         check("grant_valid", int'(grant_valid), int'(m_busy));
         check("onehot0", int'($onehot0(grant)), 1);
         check("valid_vs_grant", int'(grant_valid), int'(|grant));
         if (m_rst) for (int i = 0; i < N; i++) wait_cnt[i] = 0;
         else if (m_issue) begin
            for (int i = 0; i < N; i++) begin
               if (i == int'(grant_idx) || !m_req[i]) wait_cnt[i] = 0;
               else wait_cnt[i]++;
               if (wait_cnt[i] > 0) check("fair_wait", int'(wait_cnt[i] <= N), 1);
            end
         end
      end
   end

   task automatic step(input logic [N-1:0] r, input logic d, input logic rs);
      req  = r;
      done = d;
      rst  = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_g(input string name, input int g, input int idx);
      check({name, "_g"}, int'(grant), g);
      check({name, "_idx"}, int'(grant_idx), idx);
   endtask

   initial begin
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      step(4'b1111, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b1);
      expect_g("reset", 0, 0);
      check("reset_valid", int'(grant_valid), 0);
      step(4'b1111, 1'b1, 1'b0); expect_g("s1_a", 1, 0);
      step(4'b1111, 1'b1, 1'b0); expect_g("s1_b", 2, 1);
      step(4'b1111, 1'b1, 1'b0); expect_g("s1_c", 4, 2);
      step(4'b1111, 1'b1, 1'b0); expect_g("s1_d", 8, 3);
      step(4'b1111, 1'b1, 1'b0); expect_g("s1_e", 1, 0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b0); expect_g("s2_pre", 4, 2);
      step(4'b0011, 1'b1, 1'b0); expect_g("s2_wrap", 1, 0);
      step(4'b0011, 1'b1, 1'b0); expect_g("s2_ptr1", 2, 1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b0); expect_g("s3_pre", 4, 2);
      for (int c = 0; c < 5; c++) begin
         step(4'b0001, 1'b0, 1'b0);
         expect_g("s3_hold", 4, 2);
      end
      step(4'b0001, 1'b1, 1'b0); expect_g("s3_done", 1, 0);
      step(4'b0010, 1'b1, 1'b0); expect_g("s4_a", 2, 1);
      step(4'b0010, 1'b1, 1'b0); expect_g("s4_regrant", 2, 1);
      step(4'b0000, 1'b1, 1'b0); expect_g("s4_idle", 0, 0);
      check("s4_valid", int'(grant_valid), 0);
      step(4'b0000, 1'b1, 1'b0); expect_g("s4_done_idle", 0, 0);
      step(4'b1000, 1'b0, 1'b0); expect_g("s5_pre", 8, 3);
      step(4'b1111, 1'b1, 1'b1); expect_g("s5_rst", 0, 0);
      step(4'b1000, 1'b0, 1'b0); expect_g("s5_after", 8, 3);
      for (int c = 0; c < 10000; c++)
         step(N'($urandom), ($urandom % 3) == 0, ($urandom % 500) == 0);
      step(4'b0000, 1'b1, 1'b0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
